// File: rtl/ft_reg_bridge_pkg.sv
// Shared types and frame-format constants for the FT600 register bridge.
package ft_reg_bridge_pkg;

   localparam int DATA_W  = 16;
   localparam int OP_BIT  = 15;
   localparam int CNT_MSB = 7;
   localparam int REM_W   = CNT_MSB + 2;

   localparam logic [1:0]        BE_FULL      = 2'b11;
   localparam logic [DATA_W-1:0] TIMEOUT_DATA = 16'hDEAD;

   typedef enum logic [2:0] {
      HDR,
      ADDR,
      WDATA,
      WR_REQ,
      RD_REQ,
      RESP
   } state_t;

   function automatic logic is_rx_state(input state_t s);
      return (s == HDR) || (s == ADDR) || (s == WDATA);
   endfunction

endpackage

// File: rtl/ft_reg_bridge_if.sv
// FT user-side streams plus register bus; master is the bridge, slave is the environment.
interface ft_reg_bridge_if import ft_reg_bridge_pkg::*; #(parameter int ADDR_WIDTH = 16);

   logic [DATA_W-1:0]     rx_data;
   logic [1:0]            rx_be;
   logic                  rx_empty;
   logic                  rx_get;

   logic [DATA_W-1:0]     tx_data;
   logic [1:0]            tx_be;
   logic                  tx_valid;
   logic                  tx_full;

   logic                  reg_req;
   logic                  reg_we;
   logic [ADDR_WIDTH-1:0] reg_addr;
   logic [DATA_W-1:0]     reg_wdata;
   logic                  reg_ack;
   logic [DATA_W-1:0]     reg_rdata;

   modport master (
      input  rx_data, rx_be, rx_empty,
      output rx_get,
      output tx_data, tx_be, tx_valid,
      input  tx_full,
      output reg_req, reg_we, reg_addr, reg_wdata,
      input  reg_ack, reg_rdata
   );

   modport slave (
      output rx_data, rx_be, rx_empty,
      input  rx_get,
      input  tx_data, tx_be, tx_valid,
      output tx_full,
      input  reg_req, reg_we, reg_addr, reg_wdata,
      output reg_ack, reg_rdata
   );

endinterface

// File: rtl/ft_reg_bridge.sv
// Parses framed FT600 rx words into register writes/reads, returns read data on tx; FT_REG_BRIDGE_TIMEOUT_EN adds a reg_ack timeout.
// Latency: one cycle per parsed word, bus access issued the cycle after its last input word, read data pushed the cycle after reg_ack.
// Backpressure: rx popped only when non-empty in a parse state; RESP holds while tx_full; request held until reg_ack (or timeout).
module ft_reg_bridge import ft_reg_bridge_pkg::*; #(
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   ft_reg_bridge_if.master        bus,
   output logic                   busy,
   output logic [7:0]             err_count
);

   state_t                state_q, state_d;
   logic                  op_wr_q, op_wr_d;
   logic [REM_W-1:0]      rem_q, rem_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic [7:0]            err_q, err_d;

   logic rx_pop;
   logic be_bad;
   logic req_state;
   logic tmo_hit;
   logic err_inc;
   logic last_xfer;

   assign rx_pop    = is_rx_state(state_q) && !bus.rx_empty;
   assign be_bad    = (bus.rx_be != BE_FULL);
   assign req_state = (state_q == WR_REQ) || (state_q == RD_REQ);
   assign last_xfer = (rem_q == REM_W'(1));

`ifdef FT_REG_BRIDGE_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt;

   // Counts request cycles without ack; hit fires on the last allowed cycle.
   assign tmo_hit = req_state && !bus.reg_ack && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         tmo_cnt <= '0;
      end else if (req_state && !bus.reg_ack && !tmo_hit) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
         tmo_cnt <= '0;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= HDR;
         op_wr_q <= 1'b0;
         rem_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         op_wr_q <= op_wr_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_wr_d = op_wr_q;
      rem_d   = rem_q;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = err_q;
      err_inc = 1'b0;

      case (state_q)
         HDR: begin
            if (rx_pop) begin
               if (be_bad) begin
                  err_inc = 1'b1;
               end else begin
                  op_wr_d = bus.rx_data[OP_BIT];
                  rem_d   = {1'b0, bus.rx_data[CNT_MSB:0]} + REM_W'(1);
                  state_d = ADDR;
               end
            end
         end
         ADDR: begin
            if (rx_pop) begin
               if (be_bad) begin
                  err_inc = 1'b1;
               end else begin
                  addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
                  state_d = op_wr_q ? WDATA : RD_REQ;
               end
            end
         end
         WDATA: begin
            if (rx_pop) begin
               if (be_bad) begin
                  err_inc = 1'b1;
               end else begin
                  data_d  = bus.rx_data;
                  state_d = WR_REQ;
               end
            end
         end
         WR_REQ: begin
            // An abandoned write still consumes its slot in the frame.
            if (bus.reg_ack || tmo_hit) begin
               err_inc = tmo_hit;
               addr_d  = addr_q + ADDR_WIDTH'(1);
               rem_d   = rem_q - REM_W'(1);
               state_d = last_xfer ? HDR : WDATA;
            end
         end
         RD_REQ: begin
            if (bus.reg_ack) begin
               data_d  = bus.reg_rdata;
               state_d = RESP;
            end else if (tmo_hit) begin
               data_d  = TIMEOUT_DATA;
               err_inc = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (!bus.tx_full) begin
               addr_d  = addr_q + ADDR_WIDTH'(1);
               rem_d   = rem_q - REM_W'(1);
               state_d = last_xfer ? HDR : RD_REQ;
            end
         end
         default: begin
            state_d = HDR;
         end
      endcase

      if (err_inc && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   assign bus.rx_get    = rx_pop;
   assign bus.tx_valid  = (state_q == RESP) && !bus.tx_full;
   assign bus.tx_data   = data_q;
   assign bus.tx_be     = BE_FULL;
   assign bus.reg_req   = req_state;
   assign bus.reg_we    = (state_q == WR_REQ);
   assign bus.reg_addr  = addr_q;
   assign bus.reg_wdata = data_q;
   assign busy          = (state_q != HDR);
   assign err_count     = err_q;

   a_req_stable: assert property (@(posedge clk) disable iff (!rst)
      (bus.reg_req && !bus.reg_ack && !tmo_hit) |=>
         (bus.reg_req && $stable(bus.reg_addr) && $stable(bus.reg_we) && $stable(bus.reg_wdata)));

   a_req_drop_after_ack: assert property (@(posedge clk) disable iff (!rst)
      (bus.reg_req && bus.reg_ack) |=> !bus.reg_req);

   a_err_saturates: assert property (@(posedge clk) disable iff (!rst)
      (err_q == 8'hFF) |=> (err_q == 8'hFF));

endmodule
